// File: rtl/mem_pkg.sv
// Shared constants, types and the parity helper for the tester scratch-storage bank.
// Pure definitions: no latency, no flow control.
// The bank, its parity sub-module and the command decoder all import this package.
package mem_pkg;

    localparam int MEM_WIDTH_DEF  = 6;
    localparam int MEM_DEPTH_DEF  = 8;
    localparam int MEM_ADDR_W_DEF = (MEM_DEPTH_DEF > 1) ? $clog2(MEM_DEPTH_DEF) : 1;
    // Widest data word the parity helper accepts; narrower words are zero-extended.
    localparam int MEM_PAR_MAX_W  = 64;

    typedef struct packed {
        logic                      en;
        logic [MEM_ADDR_W_DEF-1:0] addr;
        logic [MEM_WIDTH_DEF-1:0]  data;
    } mem_req_t;

    function automatic logic calc_parity(input logic [MEM_PAR_MAX_W-1:0] dat);
        return ^dat;
    endfunction

endpackage

// File: rtl/mem_bank_par.sv
// Even-parity generate on the write path and check on the read path for mem_bank.
// Purely combinational: zero latency, no flow control.
// par_flip inverts the generated bit so that a read error can be injected on purpose.
module mem_bank_par
    import mem_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             par_flip,
    output logic             wr_par,
    input  logic [WIDTH-1:0] rd_dat,
    input  logic             rd_par,
    output logic             rd_perr
);

    assign wr_par  = calc_parity(MEM_PAR_MAX_W'(wr_dat)) ^ par_flip;
    assign rd_perr = calc_parity(MEM_PAR_MAX_W'(rd_dat)) ^ rd_par;

endmodule

// File: rtl/mem_bank.sv
// DEPTH x WIDTH flop-array scratch store: addressed write, registered read, written-flags, range errors.
// Write ack and read data appear 1 cycle after the request; one write and one read can be accepted every cycle.
// No backpressure: every in-range request is accepted. MEM_BANK_PARITY_EN adds per-entry parity and in_par_flip.
module mem_bank
    import mem_pkg::*;
#(
    parameter  int WIDTH  = MEM_WIDTH_DEF,
    parameter  int DEPTH  = MEM_DEPTH_DEF,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_wr_en,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic [WIDTH-1:0]  in_wr_data,
    output logic              mem_wrt_rd,
    input  logic              in_rd_en,
    input  logic [ADDR_W-1:0] in_rd_addr,
    output logic [WIDTH-1:0]  out_mem,
    output logic              out_rd_valid,
    input  logic              in_clr,
    output logic [DEPTH-1:0]  out_written,
    output logic              out_addr_err,
    output logic              out_rd_perr
`ifdef MEM_BANK_PARITY_EN
    ,
    input  logic              in_par_flip
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [WIDTH-1:0] out_mem_q, out_mem_d;
    logic             wrt_vld_q, wrt_vld_d;
    logic             rd_vld_q, rd_vld_d;
    logic             addr_err_q, addr_err_d;

    logic             wr_ok, rd_ok, bypass;
    logic [WIDTH-1:0] rd_dat;

    // Request decode and read mux; a same-address write in this cycle wins over stored data.
    always_comb begin
        wr_ok  = in_wr_en && ({1'b0, in_wr_addr} < DEPTH_L);
        rd_ok  = in_rd_en && ({1'b0, in_rd_addr} < DEPTH_L);
        bypass = wr_ok && (in_wr_addr == in_rd_addr);
        rd_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_rd_addr == i[ADDR_W-1:0]) begin
                rd_dat = mem_q[i];
            end
        end
        if (bypass) begin
            rd_dat = in_wr_data;
        end
    end

    always_comb begin
        mem_d      = mem_q;
        written_d  = in_clr ? '0 : written_q;
        out_mem_d  = rd_ok ? rd_dat : out_mem_q;
        wrt_vld_d  = wr_ok;
        rd_vld_d   = rd_ok;
        addr_err_d = (in_wr_en && !wr_ok) || (in_rd_en && !rd_ok);
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (in_wr_addr == i[ADDR_W-1:0])) begin
                mem_d[i]     = in_wr_data;
                written_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q  <= '0;
            out_mem_q  <= '0;
            wrt_vld_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            written_q  <= written_d;
            out_mem_q  <= out_mem_d;
            wrt_vld_q  <= wrt_vld_d;
            rd_vld_q   <= rd_vld_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign mem_wrt_rd   = wrt_vld_q;
    assign out_rd_valid = rd_vld_q;
    assign out_mem      = out_mem_q;
    assign out_written  = written_q;
    assign out_addr_err = addr_err_q;

`ifdef MEM_BANK_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             wr_par, rd_par, rd_perr;
    logic             perr_q, perr_d;

    mem_bank_par #(
        .WIDTH (WIDTH)
    ) u_par (
        .wr_dat   (in_wr_data),
        .par_flip (in_par_flip),
        .wr_par   (wr_par),
        .rd_dat   (rd_dat),
        .rd_par   (rd_par),
        .rd_perr  (rd_perr)
    );

    // Parity follows the same write-first bypass as the data it protects.
    always_comb begin
        rd_par = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_rd_addr == i[ADDR_W-1:0]) begin
                rd_par = par_q[i];
            end
        end
        if (bypass) begin
            rd_par = wr_par;
        end
    end

    always_comb begin
        par_d = par_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (in_wr_addr == i[ADDR_W-1:0])) begin
                par_d[i] = wr_par;
            end
        end
    end

    assign perr_d = rd_ok && rd_perr;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            par_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign out_rd_perr = perr_q;
`else
    assign out_rd_perr = 1'b0;
`endif

endmodule
